// File: rtl/pc_unit_if.sv
// pc_unit_if: decode-to-PC bus; master = decode/ALU side, slave = pc_unit
interface pc_unit_if #(parameter int WIDTH = 32);
  logic             branch;
  logic             jump;
  logic             branch_taken;
  logic [6:0]       opcode;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] inst_pc;
  logic             halted;
  logic             fault;
  logic [WIDTH-1:0] retired_count;
  modport master (output branch, jump, branch_taken, opcode, imm,
                  input pc, offset, inst_pc, halted, fault, retired_count);
  modport slave  (input branch, jump, branch_taken, opcode, imm,
                  output pc, offset, inst_pc, halted, fault, retired_count);
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/jump redirect, halt/fault detection, retired count
module pc_unit #(
  parameter int WIDTH = 32,
  parameter int NUM_INST = 19,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  pc_unit_if.slave bus
);
  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;
  state_t state, state_next;
  logic [WIDTH-1:0] pc, inst_pc, offset, cnt;
  logic redirect, off_bad, pc_bad;
  assign offset   = state == RUN ? inst_pc + bus.imm : '0;
  assign redirect = state == RUN && (bus.jump || (bus.branch && bus.branch_taken));
  assign off_bad  = offset[1:0] != 2'b00 || (offset >> 2) >= WIDTH'(NUM_INST);
  assign pc_bad   = (pc >> 2) >= WIDTH'(NUM_INST);
  always_ff @(posedge clk)
    state <= rst ? BOOT : state_next;
  always_comb
    state_next = state == BOOT ? RUN :
                 state != RUN ? state :
                 bus.opcode == 7'd0 ? HALT :
                 (redirect ? off_bad : pc_bad) ? FAULT : RUN;
  always_comb begin
    bus.halted        = state == HALT;
    bus.fault         = state == FAULT;
    bus.pc            = pc;
    bus.inst_pc       = inst_pc;
    bus.offset        = offset;
    bus.retired_count = cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      inst_pc <= RESET_PC;
      cnt     <= '0;
    end else begin
      if (state == BOOT) begin
        inst_pc <= RESET_PC;
        pc      <= RESET_PC + WIDTH'(4);
      end else if (state == RUN && state_next == RUN) begin
        inst_pc <= redirect ? offset : pc;
        pc      <= (redirect ? offset : pc) + WIDTH'(4);
      end
      // faulting edges still retire; only the halt NO-OP does not
      if (state == RUN && bus.opcode != 7'd0 && !(&cnt))
        cnt <= cnt + WIDTH'(1);
    end
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage directly upstream of the instruction memory/decode block in the single-cycle RISC-V core.
- Drives the fetch address `pc` and the redirect target `offset`.
- Consumes the decoded `branch`/`jump`/`opcode` plus the ALU branch-compare result and the sign-extended immediate.
- Tracks the address of the instruction currently in decode, detects the terminating NO-OP (halt) and illegal fetch addresses (fault), and counts retired instructions.

Parameters:
WIDTH, 32, address/data width in bits
NUM_INST, 19, number of words in the instruction ROM; legal word index 0..NUM_INST-1
RESET_PC, 0, byte address fetched first after reset (must be word aligned)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
branch  input  1  decoded instruction is a B-type branch
jump  input  1  decoded instruction is JAL
branch_taken  input  1  ALU compare result for the current branch; ignored when branch=0
opcode  input  7  opcode of the instruction currently in decode
imm  input  WIDTH  sign-extended immediate of the instruction in decode (byte offset)
pc  output  WIDTH  fetch byte address, registered
offset  output  WIDTH  redirect target byte address, combinational
inst_pc  output  WIDTH  byte address of the instruction currently in decode, registered
halted  output  1  high in HALT state
fault  output  1  high in FAULT state
retired_count  output  WIDTH  number of retired non-NO-OP instructions, saturating

Behaviour:
- Reset values (rst high at a clk edge): state=BOOT, pc=RESET_PC, inst_pc=RESET_PC, retired_count=0, halted=0, fault=0.
- rst has priority over everything in every state, including mid-HALT and mid-FAULT.
- States:
  - BOOT: exactly one cycle. opcode/branch/jump ignored. pc held at RESET_PC so decode latches word RESET_PC/4. Next edge: state=RUN, inst_pc<=RESET_PC, pc<=RESET_PC+4.
  - RUN: normal operation.
  - HALT: terminal until reset.
  - FAULT: terminal until reset.
- offset: in RUN, offset = inst_pc + imm (WIDTH-bit wrap, no overflow flag), valid in the same cycle as branch/jump. In every other state, offset=0.
- redirect = RUN & (jump | (branch & branch_taken)).
- RUN next-state priority, evaluated each edge:
  1. opcode==0: state<=HALT; pc and inst_pc hold; retired_count unchanged.
  2. redirect and (offset[1:0]!=0 or offset/4 >= NUM_INST): state<=FAULT; pc and inst_pc hold.
  3. redirect: inst_pc<=offset, pc<=offset+4. Decode fetches word offset/4 this cycle.
  4. no redirect and pc/4 >= NUM_INST: state<=FAULT; pc and inst_pc hold.
  5. Otherwise: inst_pc<=pc, pc<=pc+4.
- Ordering consequence: halt beats fault. A NO-OP at the last ROM word halts cleanly even though pc is already past the end.
- retired_count increments by 1 on every RUN edge with opcode!=0, including the cycle that faults. It saturates at all-ones (no wrap).
- HALT/FAULT: pc, inst_pc and retired_count frozen. halted/fault are combinational decodes of state, so they rise in the first cycle after the transitioning edge.
- Only one of branch/jump is high at a time (exclusive opcodes). If both are high, the unit treats it as a jump.
- branch=1 with branch_taken=0 is sequential (case 5).

Test Plan:
1. Reset, then opcode=7'h13, branch=jump=0 for 4 cycles -> pc sequence 0,4,8,12,16; inst_pc 0,0,4,8,12; retired_count reaches 3 after third RUN edge; halted=fault=0.
2. In RUN with inst_pc=12, pc=16: branch=1, branch_taken=1, imm=16 -> offset=28 same cycle; next edge inst_pc=28, pc=32. Repeat with branch_taken=0 -> inst_pc=16, pc=20.
3. inst_pc=32: jump=1, imm=-8 (32'hFFFFFFF8) -> offset=24; next edge inst_pc=24, pc=28. Covers negative-offset wrap arithmetic.
4. Drive opcode=0 with inst_pc=72 (word 18), pc=76 -> HALT (not FAULT); halted=1 next cycle; pc=76 frozen; retired_count frozen over 5 further cycles even with opcode!=0.
5. jump=1 with imm=6 at inst_pc=0 -> FAULT (misaligned 6); separately, imm=80 -> FAULT (word 20 >= 19); fault=1, pc/inst_pc unchanged.
6. Assert rst for one cycle while in HALT, then in FAULT -> state BOOT, pc=0, retired_count=0, halted=fault=0; normal sequencing resumes per scenario 1.
